// File: rtl/gb_pix_stream_tx_if.sv
// Producer-side pixel port and AXI4-Stream arg_1 port of the blur-core pixel transmitter.
// Define GB_TX_EOL_EN to add the arg_1_TUSER end-of-row flag.
interface gb_pix_stream_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] pix_in_data;
    logic              pix_in_valid;
    logic              pix_in_ready;
    logic [DATA_W-1:0] arg_1_TDATA;
    logic              arg_1_TVALID;
    logic              arg_1_TREADY;
    logic              arg_1_TLAST;
`ifdef GB_TX_EOL_EN
    logic              arg_1_TUSER;
`endif

    modport master (
        input  pix_in_data,
        input  pix_in_valid,
        output pix_in_ready,
        output arg_1_TDATA,
        output arg_1_TVALID,
        input  arg_1_TREADY,
        output arg_1_TLAST
`ifdef GB_TX_EOL_EN
        , output arg_1_TUSER
`endif
    );

    modport slave (
        output pix_in_data,
        output pix_in_valid,
        input  pix_in_ready,
        input  arg_1_TDATA,
        input  arg_1_TVALID,
        output arg_1_TREADY,
        input  arg_1_TLAST
`ifdef GB_TX_EOL_EN
        , input arg_1_TUSER
`endif
    );
endinterface

// File: rtl/gb_pix_stream_tx.sv
// Buffers producer pixels in a small FIFO and emits one IMG_W*IMG_H frame per start pulse on arg_1.
// Define GB_TX_EOL_EN to drive arg_1_TUSER high on the last pixel of every row.
module gb_pix_stream_tx #(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 488,
    parameter int IMG_H      = 648,
    parameter int X_W        = 9,
    parameter int Y_W        = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    gb_pix_stream_tx_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic tvalid;
    logic x_last;
    logic y_last;

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign push   = bus.pix_in_valid && !full;
    assign tvalid = (state == SEND) && !empty;
    assign pop    = tvalid && bus.arg_1_TREADY;
    assign x_last = (x == X_W'(IMG_W - 1));
    assign y_last = (y == Y_W'(IMG_H - 1));

    // Head entry is read straight from the array; it cannot change under a stall because
    // a write only lands on the head slot when the FIFO is empty.
    assign bus.pix_in_ready = !full;
    assign bus.arg_1_TVALID = tvalid;
    assign bus.arg_1_TDATA  = mem[rd_ptr];
    assign bus.arg_1_TLAST  = tvalid && x_last && y_last;
`ifdef GB_TX_EOL_EN
    assign bus.arg_1_TUSER  = tvalid && x_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is cleared too, so TDATA reads 0 out of reset instead of X.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.pix_in_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: counters advance only on beats, so TLAST/TUSER hold under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SEND;
                        busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (pop) begin
                        if (x_last) begin
                            x <= '0;
                            if (y_last) begin
                                y     <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                y <= y + Y_W'(1);
                            end
                        end else begin
                            x <= x + X_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    x     <= '0;
                    y     <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
